itch_msg_dispatcher: RTL and testbench
======================================

// Module: itch_msg_dispatcher
// PURPOSE
//  Front-end sequencer for the ITCH parser bank. Accepts the 64-bit beat stream, frames messages,
//  decodes the type byte and drives per-parser start flags plus beat counter so exactly one
//  field parser captures each message. Checks length/framing and drops bad or unknown messages.
// PARAMETERS
//  MAX_BEATS  16  max beats per message; sets counter width CW = $clog2(MAX_BEATS)
// PORTS
//  clk                    in   1    clock, rising edge
//  rst                    in   1    asynchronous reset, active-high
//  dataIn                 in   64   input beat; byte 0 = dataIn[7:0]
//  inValid                in   1    dataIn valid this cycle
//  inSop                  in   1    first beat of a message (qualified by inValid)
//  inEop                  in   1    last beat of a message (qualified by inValid)
//  dataOut                out  64   dataIn delayed one cycle, to all parsers
//  counter                out  CW   beat index of dataOut within message, first beat = 0
//  msgValid               out  1    dataOut/counter valid for the selected parser
//  startAddOrderNoMPID    out  1    type 'A' (0x41) selected, held for whole message
//  startAddOrderWithMPID  out  1    type 'F' (0x46)
//  startOrderExecuted     out  1    type 'E' (0x45)
//  startOrderDelete       out  1    type 'D' (0x44)
//  startOrderReplace      out  1    type 'U' (0x55)
//  msgDone                out  1    pulse with final beat of a good message
//  errLength              out  1    pulse: length field invalid or no EOP at expected beat
//  errTrunc               out  1    pulse: EOP or new SOP before expected beat count
//  msgCount               out  32   good messages (ITCH_STATS_EN)
//  dropCount              out  16   dropped messages (ITCH_STATS_EN)
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; internal beat count and expected count 0.
//  - First beat: dataIn[15:0] = len (bytes after length field, big-endian), dataIn[23:16] = type.
//    expBeats = (len + 2 + 7) >> 3, computed 17-bit. Latency in->out = 1 cycle, no backpressure.
//  - FSM IDLE: inValid&inSop -> known type, len >= MIN_LEN[type], expBeats <= MAX_BEATS:
//    ACTIVE, assert selected start flag, msgValid=1, counter=0. Unknown type: DROP, no flags,
//    no error. Bad len: DROP + errLength. Beats without inSop in IDLE: ignored.
//  - ACTIVE: each inValid beat -> counter+1, msgValid=1. inValid=0 -> msgValid=0, counter held.
//    Beat index expBeats-1 with inEop -> msgDone, then IDLE (flag clears next cycle).
//    Same beat without inEop -> errLength, DROP. inEop earlier -> errTrunc, IDLE.
//    inSop mid-message -> errTrunc, abort, that beat decoded as new first beat (same cycle).
//  - DROP: msgValid=0, flags 0; leave on inEop (IDLE); inSop restarts decode as in IDLE.
//  - Single-beat message (expBeats=1, inSop&inEop): msgDone same cycle as counter=0.
//  - Exactly one start flag high at a time; flags low whenever msgValid cannot be 1.
//  - counter saturates at MAX_BEATS-1 (unreachable with legal expBeats; defensive).
//  - Error pulses and msgDone 1 cycle wide, aligned with dataOut of the offending beat.
//  - rst mid-message: immediate return to IDLE, all outputs 0; next message needs inSop.
// CONFIGURATION
//  ITCH_STATS_EN defined: msgCount +1 per msgDone, dropCount +1 per message entering DROP or
//   aborted by errTrunc; both wrap; cleared by rst.
//  Not defined: counters not built; msgCount/dropCount ports kept, tied 0.
// STRUCTURE
//  itch_pkg: type codes (TYPE_A/F/E/D/U), MIN_LEN per type (A=36, F=43, E=30, D=18, U=43),
//   state enum {IDLE, ACTIVE, DROP}, beat/data width constants.
//  Sub-module itch_type_decoder: combinational type byte -> one-hot select + min-length check.
// TESTING
//  1 'F' len=43 (6 beats, EOP on 6th) -> startAddOrderWithMPID, counter 0..5, msgDone on 5, msgCount=1.
//  2 'A' len=36 with inValid=0 gaps after beats 1 and 3 -> counter holds, msgValid 0 in gaps, 5 beats.
//  3 type 0x5A len=20 -> no start flag, msgValid 0 all beats, dropCount=1, no error pulse.
//  4 'D' len=18 with inEop on beat 1 -> errTrunc at counter 1, IDLE next cycle, dropCount=1.
//  5 'E' len=30, new inSop 'D' at beat 2 -> errTrunc, startOrderDelete next, counter restarts 0.
//  6 'U' len=10 (< MIN_LEN) -> errLength on beat 0, DROP until EOP; rst mid-'A' -> outputs 0 at once.

Source files
------------

// File: rtl/itch_pkg.sv
// ITCH dispatcher shared types: message type codes, minimum lengths,
// sequencer states and the expected-beat helper.
package itch_pkg;

  localparam int DATA_W = 64;
  localparam int LEN_W  = 16;
  localparam int NSEL   = 5;

  localparam logic [7:0] TYPE_A = 8'h41;
  localparam logic [7:0] TYPE_F = 8'h46;
  localparam logic [7:0] TYPE_E = 8'h45;
  localparam logic [7:0] TYPE_D = 8'h44;
  localparam logic [7:0] TYPE_U = 8'h55;

  // select vector bit order is {A, F, E, D, U}
  localparam int SEL_A = 4;
  localparam int SEL_F = 3;
  localparam int SEL_E = 2;
  localparam int SEL_D = 1;
  localparam int SEL_U = 0;

  localparam logic [LEN_W-1:0] MIN_A = 16'd36;
  localparam logic [LEN_W-1:0] MIN_F = 16'd43;
  localparam logic [LEN_W-1:0] MIN_E = 16'd30;
  localparam logic [LEN_W-1:0] MIN_D = 16'd18;
  localparam logic [LEN_W-1:0] MIN_U = 16'd43;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DROP
  } state_t;

  typedef logic [NSEL-1:0] sel_t;

  // length field excludes its own 2 bytes
  function automatic logic [16:0] exp_beats(
    input logic [LEN_W-1:0] len
  );
    return ({1'b0, len} + 17'd9) >> 3;
  endfunction

endpackage

// File: rtl/itch_msg_dispatcher_if.sv
// Beat stream in, parser-bank control out.
// master = upstream/bench side, slave = dispatcher.
interface itch_msg_dispatcher_if
  import itch_pkg::*;
#(
  parameter int MAX_BEATS = 16
);
  localparam int CW = $clog2(MAX_BEATS);

  logic [DATA_W-1:0] dataIn;
  logic              inValid;
  logic              inSop;
  logic              inEop;
  logic [DATA_W-1:0] dataOut;
  logic [CW-1:0]     counter;
  logic              msgValid;
  logic              startAddOrderNoMPID;
  logic              startAddOrderWithMPID;
  logic              startOrderExecuted;
  logic              startOrderDelete;
  logic              startOrderReplace;
  logic              msgDone;
  logic              errLength;
  logic              errTrunc;
  logic [31:0]       msgCount;
  logic [15:0]       dropCount;

  modport master (
    output dataIn, inValid, inSop, inEop,
    input  dataOut, counter, msgValid,
    input  startAddOrderNoMPID, startAddOrderWithMPID,
    input  startOrderExecuted, startOrderDelete,
    input  startOrderReplace,
    input  msgDone, errLength, errTrunc,
    input  msgCount, dropCount
  );

  modport slave (
    input  dataIn, inValid, inSop, inEop,
    output dataOut, counter, msgValid,
    output startAddOrderNoMPID, startAddOrderWithMPID,
    output startOrderExecuted, startOrderDelete,
    output startOrderReplace,
    output msgDone, errLength, errTrunc,
    output msgCount, dropCount
  );

endinterface

// File: rtl/itch_type_decoder.sv
// Type byte -> one-hot parser select and minimum-length check.
module itch_type_decoder
  import itch_pkg::*;
(
  input  logic [7:0]       typ,
  input  logic [LEN_W-1:0] len,
  output sel_t             sel,
  output logic             known,
  output logic             min_ok
);

  logic [LEN_W-1:0] min_len;

  always_comb begin
    sel     = '0;
    min_len = '0;
    unique case (1'b1)
      (typ == TYPE_A): begin
        sel[SEL_A] = 1'b1;
        min_len    = MIN_A;
      end
      (typ == TYPE_F): begin
        sel[SEL_F] = 1'b1;
        min_len    = MIN_F;
      end
      (typ == TYPE_E): begin
        sel[SEL_E] = 1'b1;
        min_len    = MIN_E;
      end
      (typ == TYPE_D): begin
        sel[SEL_D] = 1'b1;
        min_len    = MIN_D;
      end
      (typ == TYPE_U): begin
        sel[SEL_U] = 1'b1;
        min_len    = MIN_U;
      end
      default: ;
    endcase
    known  = |sel;
    min_ok = len >= min_len;
  end

endmodule

// File: rtl/itch_msg_dispatcher.sv
// ITCH front-end sequencer: frames beats, selects one parser per message.
// Define ITCH_STATS_EN to build the good/dropped message counters.
module itch_msg_dispatcher
  import itch_pkg::*;
#(
  parameter int MAX_BEATS = 16
)(
  input logic                  clk,
  input logic                  rst,
  itch_msg_dispatcher_if.slave bus
);

  localparam int CW = $clog2(MAX_BEATS);
  localparam int EW = CW + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CMAX = cnt_t'(MAX_BEATS - 1);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d, nb;
  logic [EW-1:0] exp_q, exp_d;
  sel_t   flags_q, flags_d;
  logic   valid_q, valid_d;
  logic   done_q, done_d;
  logic   errl_q, errl_d;
  logic   errt_q, errt_d;
  logic [DATA_W-1:0] data_q;
  logic [1:0] drop_inc;

  sel_t        dec_sel;
  logic        known, min_ok, fits;
  logic [16:0] exp_full;

  assign exp_full = exp_beats(bus.dataIn[LEN_W-1:0]);
  assign fits     = exp_full <= 17'(MAX_BEATS);

  itch_type_decoder u_dec (
    .typ    (bus.dataIn[23:16]),
    .len    (bus.dataIn[LEN_W-1:0]),
    .sel    (dec_sel),
    .known  (known),
    .min_ok (min_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      errl_q  <= 1'b0;
      errt_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      errl_q  <= errl_d;
      errt_q  <= errt_d;
      data_q  <= bus.dataIn;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    flags_d  = (state_q == ACTIVE) ? flags_q : '0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    errl_d   = 1'b0;
    errt_d   = 1'b0;
    drop_inc = 2'd0;
    nb       = (cnt_q == CMAX) ? cnt_q : cnt_q + cnt_t'(1);
    if (bus.inValid) begin
      if (bus.inSop) begin
        // a new SOP aborts any message in flight, then decodes as beat 0
        if (state_q == ACTIVE) begin
          errt_d   = 1'b1;
          drop_inc = 2'd1;
        end
        cnt_d   = '0;
        flags_d = '0;
        if (known && min_ok && fits) begin
          state_d = ACTIVE;
          flags_d = dec_sel;
          valid_d = 1'b1;
          exp_d   = exp_full[EW-1:0];
          if (exp_full == 17'd1) begin
            if (bus.inEop) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              errl_d   = 1'b1;
              state_d  = DROP;
              drop_inc = drop_inc + 2'd1;
            end
          end
        end else begin
          errl_d   = known;
          state_d  = bus.inEop ? IDLE : DROP;
          drop_inc = drop_inc + 2'd1;
        end
      end else if (state_q == ACTIVE) begin
        cnt_d   = nb;
        valid_d = 1'b1;
        if (nb == cnt_t'(exp_q - EW'(1))) begin
          if (bus.inEop) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            errl_d   = 1'b1;
            state_d  = DROP;
            drop_inc = 2'd1;
          end
        end else if (bus.inEop) begin
          errt_d   = 1'b1;
          state_d  = IDLE;
          drop_inc = 2'd1;
        end
      end else if (state_q == DROP && bus.inEop) begin
        state_d = IDLE;
      end
    end
  end

  assign bus.dataOut               = data_q;
  assign bus.counter               = cnt_q;
  assign bus.msgValid              = valid_q;
  assign bus.startAddOrderNoMPID   = flags_q[SEL_A];
  assign bus.startAddOrderWithMPID = flags_q[SEL_F];
  assign bus.startOrderExecuted    = flags_q[SEL_E];
  assign bus.startOrderDelete      = flags_q[SEL_D];
  assign bus.startOrderReplace     = flags_q[SEL_U];
  assign bus.msgDone               = done_q;
  assign bus.errLength             = errl_q;
  assign bus.errTrunc              = errt_q;

`ifdef ITCH_STATS_EN
  logic [31:0] msg_q;
  logic [15:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q  <= '0;
      drop_q <= '0;
    end else begin
      msg_q  <= msg_q + 32'(done_d);
      drop_q <= drop_q + 16'(drop_inc);
    end
  end

  assign bus.msgCount  = msg_q;
  assign bus.dropCount = drop_q;
`else
  logic unused_stats;
  assign unused_stats  = ^drop_inc;
  assign bus.msgCount  = '0;
  assign bus.dropCount = '0;
`endif

endmodule

// File: tb/tb_itch_msg_dispatcher.sv
// Directed bench for itch_msg_dispatcher: framing, gaps, drops,
// truncation, length errors and asynchronous reset.
module tb_itch_msg_dispatcher;
  import itch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

`ifdef ITCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [4:0] FA = 5'b10000;
  localparam logic [4:0] FF = 5'b01000;
  localparam logic [4:0] FE = 5'b00100;
  localparam logic [4:0] FD = 5'b00010;
  localparam logic [4:0] FN = 5'b00000;

  itch_msg_dispatcher_if #(.MAX_BEATS(16)) bus ();

  itch_msg_dispatcher #(.MAX_BEATS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(
    input logic [7:0]  t,
    input logic [15:0] len
  );
    return {40'hC0FFEE1234, t, len};
  endfunction

  function automatic logic [8:0] sts();
    return {bus.msgValid,
            bus.startAddOrderNoMPID, bus.startAddOrderWithMPID,
            bus.startOrderExecuted, bus.startOrderDelete,
            bus.startOrderReplace,
            bus.msgDone, bus.errLength, bus.errTrunc};
  endfunction

  function automatic logic [8:0] es(
    input logic       v,
    input logic [4:0] f,
    input logic       d,
    input logic       el,
    input logic       et
  );
    return {v, f, d, el, et};
  endfunction

  task automatic beat(
    input logic [63:0] d,
    input logic        s,
    input logic        e
  );
    bus.dataIn  = d;
    bus.inValid = 1'b1;
    bus.inSop   = s;
    bus.inEop   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    bus.dataIn  = '0;
    bus.inValid = 1'b0;
    bus.inSop   = 1'b0;
    bus.inEop   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic counts(
    input string tag,
    input int    m,
    input int    d
  );
    chk({tag, "_msgcnt"}, 64'(bus.msgCount), STATS ? 64'(m) : 64'd0);
    chk({tag, "_dropcnt"}, 64'(bus.dropCount), STATS ? 64'(d) : 64'd0);
  endtask

  initial begin
    bus.dataIn  = '0;
    bus.inValid = 1'b0;
    bus.inSop   = 1'b0;
    bus.inEop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sts", 64'(sts()), 64'd0);
    chk("rst_cnt", 64'(bus.counter), 64'd0);
    chk("rst_data", bus.dataOut, 64'd0);
    counts("rst", 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 'F' len 43 -> 6 beats
    for (int i = 0; i < 6; i++) begin
      beat(i == 0 ? hdr(TYPE_F, 16'd43) : 64'(i) * 64'h1111,
           i == 0, i == 5);
      chk("t1_sts", 64'(sts()), 64'(es(1'b1, FF, i == 5, 1'b0, 1'b0)));
      chk("t1_cnt", 64'(bus.counter), 64'(i));
      if (i == 0) chk("t1_data", bus.dataOut, hdr(TYPE_F, 16'd43));
    end
    gap();
    chk("t1_idle", 64'(sts()), 64'd0);
    counts("t1", 1, 0);

    // 2: 'A' len 36 -> 5 beats with gaps
    beat(hdr(TYPE_A, 16'd36), 1'b1, 1'b0);
    chk("t2_b0", 64'(sts()), 64'(es(1'b1, FA, 1'b0, 1'b0, 1'b0)));
    beat(64'h1, 1'b0, 1'b0);
    chk("t2_c1", 64'(bus.counter), 64'd1);
    gap();
    chk("t2_g1", 64'(sts()), 64'(es(1'b0, FA, 1'b0, 1'b0, 1'b0)));
    chk("t2_g1c", 64'(bus.counter), 64'd1);
    beat(64'h2, 1'b0, 1'b0);
    chk("t2_c2", 64'(bus.counter), 64'd2);
    beat(64'h3, 1'b0, 1'b0);
    gap();
    chk("t2_g2", 64'(sts()), 64'(es(1'b0, FA, 1'b0, 1'b0, 1'b0)));
    chk("t2_g2c", 64'(bus.counter), 64'd3);
    beat(64'h4, 1'b0, 1'b1);
    chk("t2_done", 64'(sts()), 64'(es(1'b1, FA, 1'b1, 1'b0, 1'b0)));
    chk("t2_c4", 64'(bus.counter), 64'd4);
    gap();
    chk("t2_idle", 64'(sts()), 64'd0);
    counts("t2", 2, 0);

    // 3: unknown type dropped silently
    beat(hdr(8'h5A, 16'd20), 1'b1, 1'b0);
    chk("t3_b0", 64'(sts()), 64'd0);
    beat(64'h1, 1'b0, 1'b0);
    chk("t3_b1", 64'(sts()), 64'd0);
    beat(64'h2, 1'b0, 1'b1);
    chk("t3_b2", 64'(sts()), 64'd0);
    counts("t3", 2, 1);

    // 4: 'D' truncated at beat 1
    beat(hdr(TYPE_D, 16'd18), 1'b1, 1'b0);
    chk("t4_b0", 64'(sts()), 64'(es(1'b1, FD, 1'b0, 1'b0, 1'b0)));
    beat(64'h1, 1'b0, 1'b1);
    chk("t4_trunc", 64'(sts()), 64'(es(1'b1, FD, 1'b0, 1'b0, 1'b1)));
    chk("t4_c1", 64'(bus.counter), 64'd1);
    gap();
    chk("t4_idle", 64'(sts()), 64'd0);
    beat(64'h7, 1'b0, 1'b0);
    chk("t4_nosop", 64'(sts()), 64'd0);
    counts("t4", 2, 2);

    // 5: 'E' aborted by a new 'D' SOP at beat 2
    beat(hdr(TYPE_E, 16'd30), 1'b1, 1'b0);
    chk("t5_b0", 64'(sts()), 64'(es(1'b1, FE, 1'b0, 1'b0, 1'b0)));
    beat(64'h1, 1'b0, 1'b0);
    beat(hdr(TYPE_D, 16'd18), 1'b1, 1'b0);
    chk("t5_abort", 64'(sts()), 64'(es(1'b1, FD, 1'b0, 1'b0, 1'b1)));
    chk("t5_c0", 64'(bus.counter), 64'd0);
    beat(64'h1, 1'b0, 1'b0);
    chk("t5_c1", 64'(bus.counter), 64'd1);
    beat(64'h2, 1'b0, 1'b1);
    chk("t5_done", 64'(sts()), 64'(es(1'b1, FD, 1'b1, 1'b0, 1'b0)));
    chk("t5_c2", 64'(bus.counter), 64'd2);
    counts("t5", 3, 3);

    // 6: short 'U', oversize 'A', missing EOP
    beat(hdr(TYPE_U, 16'd10), 1'b1, 1'b0);
    chk("t6_errl", 64'(sts()), 64'(es(1'b0, FN, 1'b0, 1'b1, 1'b0)));
    beat(64'h1, 1'b0, 1'b0);
    chk("t6_drop", 64'(sts()), 64'd0);
    beat(64'h2, 1'b0, 1'b1);
    chk("t6_eop", 64'(sts()), 64'd0);
    beat(hdr(TYPE_A, 16'd200), 1'b1, 1'b1);
    chk("t6_big", 64'(sts()), 64'(es(1'b0, FN, 1'b0, 1'b1, 1'b0)));
    for (int i = 0; i < 5; i++) begin
      beat(i == 0 ? hdr(TYPE_A, 16'd36) : 64'(i), i == 0, 1'b0);
    end
    chk("t6_noeop", 64'(sts()), 64'(es(1'b1, FA, 1'b0, 1'b1, 1'b0)));
    beat(64'h5, 1'b0, 1'b0);
    chk("t6_drop2", 64'(sts()), 64'd0);
    beat(64'h6, 1'b0, 1'b1);
    chk("t6_eop2", 64'(sts()), 64'd0);
    counts("t6", 3, 6);

    // asynchronous reset in the middle of an 'A'
    beat(hdr(TYPE_A, 16'd36), 1'b1, 1'b0);
    beat(64'h1, 1'b0, 1'b0);
    chk("t7_pre", 64'(sts()), 64'(es(1'b1, FA, 1'b0, 1'b0, 1'b0)));
    #2;
    rst = 1'b1;
    #1;
    chk("t7_sts", 64'(sts()), 64'd0);
    chk("t7_cnt", 64'(bus.counter), 64'd0);
    chk("t7_data", bus.dataOut, 64'd0);
    counts("t7", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    beat(64'h2, 1'b0, 1'b0);
    chk("t7_nosop", 64'(sts()), 64'd0);
    beat(hdr(TYPE_F, 16'd43), 1'b1, 1'b0);
    chk("t7_new", 64'(sts()), 64'(es(1'b1, FF, 1'b0, 1'b0, 1'b0)));
    chk("t7_newc", 64'(bus.counter), 64'd0);
    gap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
